ctrl_pulse_checker: RTL and testbench
=====================================

Name: ctrl_pulse_checker

Overview:
- Downstream consumer of the periodic `ctrl` pulse train from the 4-bit free-running control counter. That counter's 16-cycle period has pulses at counts 7 and 12, giving alternating gaps of 5 and 11 cycles.
- Measures the cycle gap between successive rising edges and checks it against the expected alternating pattern.
- Declares lock after LOCK_N consecutive matching gaps; reports mismatches and timeouts as errors.
- Feeds status and health logic that must know the control timing is sane.

Parameters:
- CNT_W, 8, width of the gap counter and last_gap output.
- GAP_A, 5, first expected gap (cycles).
- GAP_B, 11, second expected gap (cycles). Must differ from GAP_A.
- LOCK_N, 4, consecutive matching gaps required to assert locked (range 1..15).
- TIMEOUT, 32, gap count without an edge that raises a timeout error. Must satisfy max(GAP_A,GAP_B) < TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock, shared with the pulse source.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  checker enable; low forces IDLE.
- ctrl_in  input  1  pulse train, synchronous to clk.
- clr_err  input  1  one-cycle request to clear err_count.
- locked  output  1  pattern lock indication.
- err_pulse  output  1  one-cycle pulse per detected error.
- err_count  output  8  saturating error count.
- last_gap  output  CNT_W  most recent measured gap.
- gap_valid  output  1  one-cycle pulse when last_gap updates.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, ctrl_q=0, cnt=0, match_cnt=0, expect=A.
- Edge detect: ctrl_q <= ctrl_in; edge = ctrl_in & ~ctrl_q. A held-high input counts as one edge.
- Gap counter, in every non-IDLE state:
  - on edge, cnt <= 1;
  - otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - For edges in cycles t0 and t1, cnt = t1-t0 in cycle t1.
- Gap measurement: on every edge after the first in a run, last_gap <= cnt and gap_valid=1 in the next cycle. The edge in WAIT_FIRST produces no gap.
- Timeout: cnt==TIMEOUT with no edge in WAIT_SECOND, TRACK or LOCKED -> error, go to WAIT_FIRST. If an edge and a timeout occur in the same cycle, the edge wins.
- FSM:
  - IDLE: enable=1 -> WAIT_FIRST (cnt=0).
  - WAIT_FIRST: edge -> WAIT_SECOND. No timeout in this state.
  - WAIT_SECOND:
    - edge with gap==GAP_A -> TRACK, expect=B, match_cnt=1;
    - edge with gap==GAP_B -> TRACK, expect=A, match_cnt=1;
    - any other gap -> error, stay in WAIT_SECOND (this edge becomes the new reference).
  - TRACK:
    - edge with gap==expected -> match_cnt+1 and toggle expect; when match_cnt+1==LOCK_N -> LOCKED.
    - edge with mismatch -> error, WAIT_SECOND, match_cnt=0.
  - LOCKED:
    - edge with gap==expected -> toggle expect, stay LOCKED.
    - mismatch -> error, WAIT_SECOND.
    - timeout -> error, WAIT_FIRST.
  - LOCK_N=1: the first good gap goes straight to LOCKED.
- Output timing:
  - locked is registered: 1 exactly while the FSM is in LOCKED, i.e. from the cycle after the locking edge.
  - locked drops in the cycle after the error edge or timeout.
- Errors:
  - err_pulse is registered, high for one cycle after each error cycle.
  - err_count saturates at 255.
  - clr_err alone -> err_count=0.
  - clr_err together with an error -> err_count=1.
  - err_count is not cleared by enable.
- enable low in any state -> IDLE on the next cycle: locked=0, cnt=0, match_cnt=0, expect=A. last_gap and err_count hold. Re-enabling restarts at WAIT_FIRST.
- rst mid-operation overrides everything, including an edge in the same cycle.

Test Plan:
- Nominal lock: rst, enable=1, source pulses at counts 7 and 12 of a 16-cycle period (first edge at cycle t) -> last_gap sequence 5,11,5,11; locked=1 from cycle t+33; err_count=0.
- Glitch: after lock, inject an extra 1-cycle pulse 3 cycles after a count-7 pulse -> err_pulse once, locked=0, err_count=1, last_gap=3. The next gap (2) is also an error (err_count=2). Relock after LOCK_N further good gaps.
- Timeout: after lock, hold ctrl_in=0 -> err_pulse one cycle after cnt reaches 32, FSM in WAIT_FIRST, locked=0. Resuming the pulses relocks on the 5th subsequent edge.
- Held-high input: ctrl_in=1 for 20 cycles from enable -> one edge only, then timeout error at cnt=32; err_count=1.
- Clear/saturation: force 300 errors with random gaps -> err_count=255. clr_err pulse -> 0. clr_err in the same cycle as an error -> 1.
- Enable/reset mid-run: drop enable while LOCKED -> locked=0 next cycle, err_count held. Assert rst in the same cycle as an edge -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/ctrl_pulse_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pulse_checker_if
//  Brief    : Control/status bundle between a ctrl pulse checker and its host.
//  Revision : 1.0  initial release
// ============================================================================
interface ctrl_pulse_checker_if #(
    parameter int CNT_W = 8
) ();
    logic             enable;
    logic             ctrl_in;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_count;
    logic [CNT_W-1:0] last_gap;
    logic             gap_valid;

    modport master (
        output enable, ctrl_in, clr_err,
        input  locked, err_pulse, err_count, last_gap, gap_valid
    );

    modport slave (
        input  enable, ctrl_in, clr_err,
        output locked, err_pulse, err_count, last_gap, gap_valid
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pulse_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pulse_checker
//  Brief    : Measures gaps between ctrl rising edges, locks onto the
//             alternating GAP_A/GAP_B pattern and counts timing errors.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_pulse_checker #(
    parameter int CNT_W   = 8,
    parameter int GAP_A   = 5,
    parameter int GAP_B   = 11,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ctrl_pulse_checker_if.slave bus
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_WAIT_FIRST  = 3'd1;
    localparam logic [2:0] c_WAIT_SECOND = 3'd2;
    localparam logic [2:0] c_TRACK       = 3'd3;
    localparam logic [2:0] c_LOCKED      = 3'd4;

    localparam logic [CNT_W-1:0] c_GAP_A   = CNT_W'(GAP_A);
    localparam logic [CNT_W-1:0] c_GAP_B   = CNT_W'(GAP_B);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [3:0]       c_LOCK_N  = 4'(LOCK_N);
    localparam logic [2:0]       c_FIRST_GOOD_STATE = (LOCK_N == 1) ? c_LOCKED : c_TRACK;

    logic [2:0]       r_state;
    logic             r_ctrl_q;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_match_cnt;
    logic             r_expect_b;
    logic             r_locked;
    logic             r_err_pulse;
    logic [7:0]       r_err_count;
    logic [CNT_W-1:0] r_last_gap;
    logic             r_gap_valid;

    logic             w_edge;
    logic             w_tracking;
    logic             w_gap_is_a;
    logic             w_gap_is_b;
    logic             w_match_exp;
    logic             w_gap_ok;
    logic             w_timeout;
    logic             w_err;
    logic [3:0]       w_match_next;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_edge       = bus.ctrl_in & ~r_ctrl_q;
    assign w_tracking   = (r_state == c_WAIT_SECOND) | (r_state == c_TRACK) | (r_state == c_LOCKED);
    assign w_gap_is_a   = (r_cnt == c_GAP_A);
    assign w_gap_is_b   = (r_cnt == c_GAP_B);
    assign w_match_exp  = r_expect_b ? w_gap_is_b : w_gap_is_a;
    // Before a phase is established either pattern gap is acceptable.
    assign w_gap_ok     = (r_state == c_WAIT_SECOND) ? (w_gap_is_a | w_gap_is_b) : w_match_exp;
    assign w_timeout    = (r_cnt == c_TIMEOUT) & ~w_edge;
    assign w_err        = bus.enable & w_tracking & ((w_edge & ~w_gap_ok) | w_timeout);
    assign w_match_next = r_match_cnt + 4'd1;
    assign w_cnt_next   = w_edge ? CNT_W'(1)
                        : ((r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ctrl_q    <= 1'b0;
            r_cnt       <= '0;
            r_match_cnt <= 4'd0;
            r_expect_b  <= 1'b0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= 8'd0;
            r_last_gap  <= '0;
            r_gap_valid <= 1'b0;
        end else begin
            r_ctrl_q    <= bus.ctrl_in;
            r_gap_valid <= 1'b0;
            r_err_pulse <= w_err;

            if (w_err) begin
                r_err_count <= bus.clr_err ? 8'd1
                             : ((r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1);
            end else if (bus.clr_err) begin
                r_err_count <= 8'd0;
            end

            if (!bus.enable) begin
                r_state     <= c_IDLE;
                r_cnt       <= '0;
                r_match_cnt <= 4'd0;
                r_expect_b  <= 1'b0;
                r_locked    <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_WAIT_FIRST;
                        r_cnt   <= '0;
                    end
                    c_WAIT_FIRST: begin
                        r_cnt <= w_cnt_next;
                        if (w_edge) begin
                            r_state <= c_WAIT_SECOND;
                        end
                    end
                    c_WAIT_SECOND, c_TRACK, c_LOCKED: begin
                        r_cnt <= w_cnt_next;
                        if (w_edge) begin
                            r_last_gap  <= r_cnt;
                            r_gap_valid <= 1'b1;
                            if (r_state == c_WAIT_SECOND) begin
                                // A bad gap here just re-references on this edge.
                                if (w_gap_is_a || w_gap_is_b) begin
                                    r_state     <= c_FIRST_GOOD_STATE;
                                    r_expect_b  <= w_gap_is_a;
                                    r_match_cnt <= 4'd1;
                                    r_locked    <= (LOCK_N == 1);
                                end
                            end else if (w_match_exp) begin
                                r_expect_b <= ~r_expect_b;
                                if (r_state == c_TRACK) begin
                                    r_match_cnt <= w_match_next;
                                    if (w_match_next == c_LOCK_N) begin
                                        r_state  <= c_LOCKED;
                                        r_locked <= 1'b1;
                                    end
                                end
                            end else begin
                                r_state     <= c_WAIT_SECOND;
                                r_match_cnt <= 4'd0;
                                r_expect_b  <= 1'b0;
                                r_locked    <= 1'b0;
                            end
                        end else if (w_timeout) begin
                            r_state     <= c_WAIT_FIRST;
                            r_match_cnt <= 4'd0;
                            r_expect_b  <= 1'b0;
                            r_locked    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.last_gap  = r_last_gap;
    assign bus.gap_valid = r_gap_valid;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pulse_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_pulse_checker
//  Brief    : Directed plus randomized bench for ctrl_pulse_checker with a
//             timestamp-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_pulse_checker;

    localparam int CNT_W   = 8;
    localparam int GAP_A   = 5;
    localparam int GAP_B   = 11;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_pulse_checker_if #(.CNT_W(CNT_W)) bus ();

    ctrl_pulse_checker #(
        .CNT_W   (CNT_W),
        .GAP_A   (GAP_A),
        .GAP_B   (GAP_B),
        .LOCK_N  (LOCK_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: remembers the time of the last reference edge and the
    // gap it expects next (0 = either pattern gap accepted).
    int m_cyc      = 0;
    int m_ref      = -1;
    bit m_active   = 1'b0;
    int m_streak   = 0;
    int m_expgap   = 0;
    bit m_prev     = 1'b0;
    int m_errs     = 0;
    int m_last_gap = 0;
    bit m_gv       = 1'b0;
    bit m_ep       = 1'b0;
    bit m_locked   = 1'b0;
    int src_pos    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        bit rise;
        bit err;
        int g;
        m_cyc++;
        if (rst) begin
            m_ref = -1; m_active = 0; m_streak = 0; m_expgap = 0; m_prev = 0;
            m_errs = 0; m_last_gap = 0; m_gv = 0; m_ep = 0; m_locked = 0;
            return;
        end
        rise   = bus.ctrl_in && !m_prev;
        m_prev = bus.ctrl_in;
        err    = 0;
        m_gv   = 0;
        if (!bus.enable) begin
            m_active = 0; m_ref = -1; m_streak = 0; m_expgap = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (m_ref < 0) begin
            if (rise) m_ref = m_cyc;
        end else begin
            g = m_cyc - m_ref;
            if (g > 255) g = 255;
            if (rise) begin
                m_gv = 1; m_last_gap = g; m_ref = m_cyc;
                if (m_expgap == 0) begin
                    if (g == GAP_A) begin m_expgap = GAP_B; m_streak = 1; end
                    else if (g == GAP_B) begin m_expgap = GAP_A; m_streak = 1; end
                    else err = 1;
                end else if (g == m_expgap) begin
                    m_streak++;
                    m_expgap = (m_expgap == GAP_A) ? GAP_B : GAP_A;
                end else begin
                    err = 1; m_streak = 0; m_expgap = 0;
                end
            end else if (g == TIMEOUT) begin
                err = 1; m_ref = -1; m_streak = 0; m_expgap = 0;
            end
        end
        m_locked = m_active && (m_streak >= LOCK_N);
        m_ep     = err;
        if (err) m_errs = bus.clr_err ? 1 : ((m_errs >= 255) ? 255 : m_errs + 1);
        else if (bus.clr_err) m_errs = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("locked",    bus.locked,    m_locked);
        chk("err_pulse", bus.err_pulse, m_ep);
        chk("err_count", bus.err_count, m_errs);
        chk("last_gap",  bus.last_gap,  m_last_gap);
        chk("gap_valid", bus.gap_valid, m_gv);
    endtask

    task automatic src(input int n, input bit glitch);
        for (int k = 0; k < n; k++) begin
            bus.ctrl_in = (src_pos == 7) || (src_pos == 12) || (glitch && src_pos == 10);
            tick();
            src_pos = (src_pos + 1) % 16;
        end
    endtask

    initial begin
        int g;
        rst = 1; bus.enable = 0; bus.ctrl_in = 0; bus.clr_err = 0;
        tick(); tick();
        chk("rst_locked", bus.locked, 0);
        chk("rst_errcnt", bus.err_count, 0);
        chk("rst_gap",    bus.last_gap, 0);

        // Nominal lock, first edge on the first source cycle
        rst = 0; bus.enable = 1;
        tick();
        src_pos = 7;
        src(32, 0);
        chk("nom_not_yet_locked", bus.locked, 0);
        src(1, 0);
        chk("nom_locked_t33", bus.locked, 1);
        chk("nom_last_gap", bus.last_gap, GAP_B);
        chk("nom_errcnt", bus.err_count, 0);
        src($urandom_range(0, 40), 0);

        // Glitch 3 cycles after a count-7 pulse
        while (src_pos != 0) src(1, 0);
        src(11, 1);
        chk("glitch_pulse", bus.err_pulse, 1);
        chk("glitch_gap", bus.last_gap, 3);
        chk("glitch_unlocked", bus.locked, 0);
        src(5, 1);
        chk("glitch_errcnt", bus.err_count, 2);
        src(64, 0);
        chk("glitch_relock", bus.locked, 1);

        // Timeout with ctrl held low
        bus.ctrl_in = 0;
        repeat (40) tick();
        chk("to_unlocked", bus.locked, 0);
        chk("to_errcnt", bus.err_count, 3);
        src(64, 0);
        chk("to_relock", bus.locked, 1);

        // Enable drop while locked
        bus.enable = 0; bus.ctrl_in = 0;
        tick();
        chk("en_unlocked", bus.locked, 0);
        chk("en_errcnt_held", bus.err_count, 3);
        repeat ($urandom_range(1, 5)) tick();

        // Held-high input: one edge then a timeout
        bus.enable = 1;
        tick();
        bus.ctrl_in = 1;
        repeat (20) tick();
        bus.ctrl_in = 0;
        repeat (20) tick();
        chk("held_errcnt", bus.err_count, 4);

        // Error storm to saturation using gaps that never fit the pattern
        for (int i = 0; i < 300; i++) begin
            bus.ctrl_in = 1;
            tick();
            do g = $urandom_range(2, 20); while (g == GAP_A || g == GAP_B);
            bus.ctrl_in = 0;
            repeat (g - 1) tick();
        end
        chk("sat_errcnt", bus.err_count, 255);
        bus.ctrl_in = 1; tick();
        bus.ctrl_in = 0; bus.clr_err = 1; tick();
        chk("clr_alone", bus.err_count, 0);
        bus.clr_err = 0; tick();
        bus.ctrl_in = 1; bus.clr_err = 1; tick();
        chk("clr_with_err", bus.err_count, 1);
        chk("clr_with_err_pulse", bus.err_pulse, 1);
        bus.clr_err = 0; bus.ctrl_in = 0;

        // Reset coincident with a rising edge
        src(64, 0);
        while (src_pos != 7) src(1, 0);
        bus.ctrl_in = 1; rst = 1;
        tick();
        chk("rst_edge_locked", bus.locked, 0);
        chk("rst_edge_errcnt", bus.err_count, 0);
        chk("rst_edge_gap", bus.last_gap, 0);
        chk("rst_edge_gv", bus.gap_valid, 0);
        chk("rst_edge_ep", bus.err_pulse, 0);
        rst = 0; src_pos = 8;

        // Random mix of pattern, glitches, enable drops, clears and resets
        for (int i = 0; i < 800; i++) begin
            bus.enable  = ($urandom_range(0, 99) != 0);
            bus.clr_err = ($urandom_range(0, 49) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            bus.ctrl_in = ((src_pos == 7) || (src_pos == 12)) ^ ($urandom_range(0, 29) == 0);
            tick();
            src_pos = (src_pos + 1) % 16;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
